// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU port, loader port and RAM port signals around ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the side that
// issues requests and owns the RAM macro.
interface ram_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  // CPU fetch/execute port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  // Loader (debug/programming) port
  logic          ldr_req;
  logic          ldr_lock;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic          ldr_rvalid;
  logic [DW-1:0] ldr_rdata;

  // Single-port RAM side
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_lock, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output ldr_req, ldr_lock, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port program/data RAM between the CPU
// and the program loader. Grants are combinational (zero-cycle), read data is
// steered back to the requester one cycle later, and the loader may hold the
// RAM for a bounded burst with ldr_lock.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | round-robin between CPU and loader, last_owner breaks ties
// ST_LOCKED | loader owns the RAM; CPU stalled until lock drops or count hits
//           | MAX_LOCK
module ram_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  // A one-grant lock is already exhausted by the grant that would enter it.
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;
  typedef enum logic {OWN_CPU, OWN_LDR} owner_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_LDR} tag_e;

  state_e        state_q, state_d;
  owner_e        last_owner_q, last_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  tag_e          rd_tag_q, rd_tag_d;

  logic cpu_gnt;
  logic ldr_gnt;

  // State register; last_owner resets to LDR so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_LDR;
      lock_cnt_q   <= '0;
      rd_tag_q     <= TAG_NONE;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // Grant decision, lock bookkeeping and next-state.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    cpu_gnt      = 1'b0;
    ldr_gnt      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req && bus.ldr_req) begin
          if (last_owner_q == OWN_LDR) cpu_gnt = 1'b1;
          else                         ldr_gnt = 1'b1;
        end else begin
          cpu_gnt = bus.cpu_req;
          ldr_gnt = bus.ldr_req;
        end

        if (cpu_gnt) last_owner_d = OWN_CPU;
        if (ldr_gnt) begin
          last_owner_d = OWN_LDR;
          if (bus.ldr_lock && LOCK_EN) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = CW'(1);
          end
        end
      end

      ST_LOCKED: begin
        ldr_gnt = bus.ldr_req;
        if (ldr_gnt) lock_cnt_d = lock_cnt_q + CW'(1);
        // Leaving with last_owner=LDR hands the next tie to the CPU.
        if (!bus.ldr_lock || (ldr_gnt && (lock_cnt_q == CW'(MAX_LOCK - 1)))) begin
          state_d      = ST_IDLE;
          last_owner_d = OWN_LDR;
          lock_cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Remember who owns the read issued this cycle so its data returns there.
  always_comb begin
    rd_tag_d = TAG_NONE;
    if (cpu_gnt && !bus.cpu_we)      rd_tag_d = TAG_CPU;
    else if (ldr_gnt && !bus.ldr_we) rd_tag_d = TAG_LDR;
  end

  // RAM port mux; everything held at zero when nobody is granted.
  always_comb begin
    bus.ram_en    = cpu_gnt | ldr_gnt;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (cpu_gnt) begin
      bus.ram_we    = bus.cpu_we;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (ldr_gnt) begin
      bus.ram_we    = bus.ldr_we;
      bus.ram_addr  = bus.ldr_addr;
      bus.ram_wdata = bus.ldr_wdata;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ldr_gnt    = ldr_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;

  assign bus.cpu_rvalid = (rd_tag_q == TAG_CPU);
  assign bus.ldr_rvalid = (rd_tag_q == TAG_LDR);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : '0;
  assign bus.ldr_rdata  = bus.ldr_rvalid ? bus.ram_rdata : '0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 16x8 program/data RAM between the CPU fetch/execute path and the external program loader. During execution the controller's MEM_LOAD/MEM_EN accesses arrive on the CPU port, and the loader (debug/programming port) competes on the second port. The block grants one access per cycle under round-robin, supports a bounded loader lock for programming bursts, routes read data back with a 1-cycle latency tag, and raises a stall toward the controller when the CPU is not granted.

## Interface
- AW, 4, address width (16 words)
- DW, 8, data width
- MAX_LOCK, 16, max consecutive loader grants under lock before forced release (1..2^AW)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DW  CPU read data; 0 when cpu_rvalid=0
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- ldr_req  in  1  loader access request
- ldr_lock  in  1  loader requests to keep ownership
- ldr_we  in  1  loader write / read
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_gnt  out  1  loader access accepted (combinational)
- ldr_rvalid  out  1  loader read data valid (registered)
- ldr_rdata  out  DW  loader read data; 0 when ldr_rvalid=0
- ram_en  out  1  RAM access strobe (= cpu_gnt | ldr_gnt)
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid 1 cycle after a read strobe

## Operation
- Access accepted when req & gnt in same cycle; at most one gnt high per cycle.
- RAM port signals muxed from granted requester; all zero when no grant.
- State: IDLE, LOCKED; registers last_owner (CPU/LDR), lock_cnt (width to hold MAX_LOCK), rd_tag (none/CPU/LDR).
- IDLE: only one req -> grant it. Both req -> grant requester that is not last_owner. last_owner updates on every grant.
- IDLE -> LOCKED when loader granted with ldr_lock=1; lock_cnt <= 1.
- LOCKED: cpu_gnt=0 always; ldr_gnt = ldr_req. Each loader grant increments lock_cnt.
- LOCKED -> IDLE when ldr_lock=0 (sampled any cycle), or on the loader grant that brings lock_cnt to MAX_LOCK; on exit last_owner=LDR so a pending CPU wins next cycle. Lock re-entry requires at least one IDLE arbitration cycle.
- Loader idle in LOCKED (ldr_req=0, ldr_lock=1): no grant, lock_cnt unchanged, CPU stays stalled.
- Read accepted -> rd_tag set to owner; next cycle that port's rvalid=1, rdata=ram_rdata. Writes produce no rvalid.
- Simultaneous requests to same address: only the granted access occurs; the other sees stall and retries; no merging.

## Timing
- Reset: state=IDLE, last_owner=LDR (CPU wins first contention), lock_cnt=0, rd_tag=none; cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata = 0. Combinational outputs follow inputs with that state.
- Grant latency: 0 cycles (same cycle as req). Read latency: 1 cycle from accepted read to rvalid.
- Back-to-back reads supported every cycle; rvalid is a single-cycle pulse per read.
- rst during LOCKED or with read in flight: next cycle IDLE, rd_tag cleared, no rvalid for the in-flight read.
- cpu_stall is combinational; controller must hold req/addr/we/wdata stable until granted.

## Test plan
- Reset then idle: all outputs 0; cpu_req=1 read addr 3 (RAM[3]=0x2A) -> cpu_gnt=1 same cycle, cpu_rvalid=1, cpu_rdata=0x2A next cycle.
- Both request every cycle, no lock -> grants alternate CPU, LDR, CPU, LDR; cpu_stall high on LDR cycles.
- Loader lock burst writing 0x10..0x1F to addr 0..15 with CPU requesting -> 16 consecutive ldr_gnt, cpu_stall=1 throughout, CPU granted cycle 17; with MAX_LOCK=4 CPU granted after 4 loader grants, then alternation.
- ldr_lock dropped after 3 grants -> IDLE next cycle, CPU granted next contention.
- Same-cycle loader write 0x55 and CPU read, addr 7, last_owner=CPU -> loader granted, CPU read next cycle returns 0x55.
- rst asserted in LOCKED with loader read in flight -> no ldr_rvalid, state IDLE, CPU wins first contention after reset.
